// File: rtl/regs_wb_arbiter.sv
// regs_wb_arbiter
//
// Merges register-file write requests from the main pipeline write-back
// stage (WB) and the multi-cycle mul/div unit (MD) into one registered
// register-file write port. Each requester owns a one-entry buffer. One
// buffer is drained per cycle. WB wins by default, and a starvation counter
// forces MD through after STARVE_MAX consecutive losses.
//
// Parameters
//   STARVE_MAX  cycles a full MD buffer may lose before it is forced to win (1..15)
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   wb_valid   in   WB write request
//   wb_addr    in   WB destination register
//   wb_data    in   WB write data
//   wb_ready   out  WB buffer can accept this cycle
//   md_valid   in   MD write request
//   md_addr    in   MD destination register
//   md_data    in   MD write data
//   md_ready   out  MD buffer can accept this cycle
//   L_S        out  register-file write enable (registered)
//   Wt_addr    out  register-file write address (registered)
//   Wt_data    out  register-file write data (registered)
//   pend_mask  out  one bit per register with a buffered, not yet driven write

module regs_wb_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_ready,

    input  logic        md_valid,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        md_ready,

    output logic        L_S,
    output logic [4:0]  Wt_addr,
    output logic [31:0] Wt_data,
    output logic [31:0] pend_mask
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    // One-entry buffers.
    logic        wb_full_q, wb_full_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic        md_full_q, md_full_d;
    logic [4:0]  md_addr_q, md_addr_d;
    logic [31:0] md_data_q, md_data_d;

    logic [3:0]  starve_q, starve_d;

    // Registered write port.
    logic        ls_q, ls_d;
    logic [4:0]  wt_addr_q, wt_addr_d;
    logic [31:0] wt_data_q, wt_data_d;

    logic wb_grant;
    logic md_grant;
    logic wb_accept;
    logic md_accept;

    // Arbitration: WB wins unless MD has been passed over STARVE_MAX times
    // in a row.
    always_comb begin
        wb_grant = wb_full_q && !(md_full_q && (starve_q == StarveMax));
        md_grant = md_full_q && !wb_grant;
    end

    // Ready also covers a buffer being drained this cycle, so a buffer can
    // take a new entry on every edge.
    always_comb begin
        wb_ready  = !wb_full_q || wb_grant;
        md_ready  = !md_full_q || md_grant;
        wb_accept = wb_valid && wb_ready;
        md_accept = md_valid && md_ready;
    end

    // Buffer next state. A refill on the drain edge takes priority over the clear.
    always_comb begin
        wb_full_d = wb_full_q && !wb_grant;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (wb_accept) begin
            wb_full_d = 1'b1;
            wb_addr_d = wb_addr;
            wb_data_d = wb_data;
        end

        md_full_d = md_full_q && !md_grant;
        md_addr_d = md_addr_q;
        md_data_d = md_data_q;
        if (md_accept) begin
            md_full_d = 1'b1;
            md_addr_d = md_addr;
            md_data_d = md_data;
        end
    end

    // Starvation counter. It counts only while MD waits behind WB.
    always_comb begin
        starve_d = starve_q;
        if (!md_full_q || md_grant) begin
            starve_d = 4'd0;
        end else if (starve_q < StarveMax) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Write port. Address and data hold when nothing drains. Writes to r0
    // drain without raising the enable.
    always_comb begin
        ls_d      = 1'b0;
        wt_addr_d = wt_addr_q;
        wt_data_d = wt_data_q;
        if (wb_grant) begin
            ls_d      = (wb_addr_q != 5'd0);
            wt_addr_d = wb_addr_q;
            wt_data_d = wb_data_q;
        end else if (md_grant) begin
            ls_d      = (md_addr_q != 5'd0);
            wt_addr_d = md_addr_q;
            wt_data_d = md_data_q;
        end
    end

    // Pending mask from the buffer contents. r0 never shows as pending.
    always_comb begin
        pend_mask = 32'd0;
        if (wb_full_q) begin
            pend_mask[wb_addr_q] = 1'b1;
        end
        if (md_full_q) begin
            pend_mask[md_addr_q] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_full_q <= 1'b0;
            wb_addr_q <= 5'd0;
            wb_data_q <= 32'd0;
            md_full_q <= 1'b0;
            md_addr_q <= 5'd0;
            md_data_q <= 32'd0;
            starve_q  <= 4'd0;
            ls_q      <= 1'b0;
            wt_addr_q <= 5'd0;
            wt_data_q <= 32'd0;
        end else begin
            wb_full_q <= wb_full_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            md_full_q <= md_full_d;
            md_addr_q <= md_addr_d;
            md_data_q <= md_data_d;
            starve_q  <= starve_d;
            ls_q      <= ls_d;
            wt_addr_q <= wt_addr_d;
            wt_data_q <= wt_data_d;
        end
    end

    assign L_S     = ls_q;
    assign Wt_addr = wt_addr_q;
    assign Wt_data = wt_data_q;

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Randomised and directed bench for regs_wb_arbiter. The reference model
// holds each requester's pending entries in a queue and applies the
// arbitration and starvation rules to those queues, then predicts the
// ready flags, the pending mask and the registered write port.

`timescale 1ns/1ps

module tb_regs_wb_arbiter;

    localparam int unsigned SM = 3;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        L_S;
    logic [4:0]  Wt_addr;
    logic [31:0] Wt_data;
    logic [31:0] pend_mask;

    regs_wb_arbiter #(
        .STARVE_MAX(SM)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .wb_ready (wb_ready),
        .md_valid (md_valid),
        .md_addr  (md_addr),
        .md_data  (md_data),
        .md_ready (md_ready),
        .L_S      (L_S),
        .Wt_addr  (Wt_addr),
        .Wt_data  (Wt_data),
        .pend_mask(pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    // Reference model state.
    ent_t        wb_q[$];
    ent_t        md_q[$];
    int unsigned starve;
    logic        exp_ls;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [31:0] rf[32];

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        wb_q.delete();
        md_q.delete();
        starve   = 0;
        exp_ls   = 1'b0;
        exp_addr = 5'd0;
        exp_data = 32'd0;
    endtask

    // One clock cycle. It is entered and left on a falling edge.
    task automatic step(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
        bit          md_full;
        bit          g_wb;
        bit          g_md;
        bit          r_wb;
        bit          r_md;
        logic [31:0] pend;
        ent_t        e;

        check_eq("L_S", {31'd0, L_S}, {31'd0, exp_ls});
        check_eq("Wt_addr", {27'd0, Wt_addr}, {27'd0, exp_addr});
        check_eq("Wt_data", Wt_data, exp_data);

        wb_valid = wv;
        wb_addr  = wa;
        wb_data  = wd;
        md_valid = mv;
        md_addr  = ma;
        md_data  = md;
        #1;

        md_full = (md_q.size() != 0);
        g_wb    = (wb_q.size() != 0) && !(md_full && starve == SM);
        g_md    = md_full && !g_wb;
        r_wb    = (wb_q.size() == 0) || g_wb;
        r_md    = !md_full || g_md;
        pend    = 32'd0;
        foreach (wb_q[i]) if (wb_q[i].addr != 5'd0) pend |= 32'd1 << wb_q[i].addr;
        foreach (md_q[i]) if (md_q[i].addr != 5'd0) pend |= 32'd1 << md_q[i].addr;

        check_eq("wb_ready", {31'd0, wb_ready}, {31'd0, r_wb});
        check_eq("md_ready", {31'd0, md_ready}, {31'd0, r_md});
        check_eq("pend_mask", pend_mask, pend);

        @(posedge clk);
        exp_ls = 1'b0;
        if (g_wb || g_md) begin
            e        = g_wb ? wb_q.pop_front() : md_q.pop_front();
            exp_ls   = (e.addr != 5'd0);
            exp_addr = e.addr;
            exp_data = e.data;
            if (exp_ls) rf[e.addr] = e.data;
        end
        if (md_full && !g_md) starve = (starve < SM) ? starve + 1 : starve;
        else starve = 0;
        if (wv && r_wb) wb_q.push_back({wa, wd});
        if (mv && r_md) md_q.push_back({ma, md});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Assert reset on a falling edge and check that it takes effect at once,
    // then release it on the next falling edge.
    task automatic do_reset();
        rst_n    = 1'b0;
        wb_valid = 1'b1;
        md_valid = 1'b1;
        #1;
        check_eq("rst L_S", {31'd0, L_S}, 32'd0);
        check_eq("rst Wt_addr", {27'd0, Wt_addr}, 32'd0);
        check_eq("rst Wt_data", Wt_data, 32'd0);
        check_eq("rst pend_mask", pend_mask, 32'd0);
        check_eq("rst wb_ready", {31'd0, wb_ready}, 32'd1);
        check_eq("rst md_ready", {31'd0, md_ready}, 32'd1);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        wb_valid = 1'b0;
        md_valid = 1'b0;
    endtask

    initial begin
        logic        wv;
        logic        mv;
        logic [4:0]  wa;
        logic [4:0]  ma;

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        wb_valid = 1'b0;
        wb_addr  = 5'd0;
        wb_data  = 32'd0;
        md_valid = 1'b0;
        md_addr  = 5'd0;
        md_data  = 32'd0;
        foreach (rf[i]) rf[i] = 32'd0;
        model_clear();
        @(negedge clk);
        do_reset();

        // Single WB write.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        idle(3);

        // Simultaneous WB and MD requests.
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        idle(3);

        // Continuous WB traffic with one MD entry waiting.
        step(1'b1, 5'd1, 32'h100, 1'b1, 5'd7, 32'h77);
        for (int i = 0; i < 8; i++) step(1'b1, 5'(i + 10), 32'(i), 1'b0, 5'd0, 32'd0);
        idle(3);
        check_eq("r7 final", rf[7], 32'h77);

        // Write to r0.
        step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
        idle(3);

        // Same address in both buffers.
        step(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB);
        idle(3);
        check_eq("r9 final", rf[9], 32'hB);

        // Reset with both buffers full.
        step(1'b1, 5'd2, 32'h2222, 1'b1, 5'd6, 32'h6666);
        do_reset();
        idle(3);
        check_eq("r2 untouched", rf[2], 32'd0);
        check_eq("r6 untouched", rf[6], 32'd0);

        // Random traffic. Addresses are biased toward a few registers so that
        // conflicts and r0 writes occur often.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                wv = ($urandom_range(0, 9) < 8);
                mv = ($urandom_range(0, 9) < 4);
                wa = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
                ma = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
                step(wv, wa, $urandom, mv, ma, $urandom);
            end
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
